// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM states, the NOP encoding and
// the default reset PC.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with +4 increment and redirect load, plus the registered
// PC / PC+4 of the instruction currently captured for decode.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_pc,
   input  logic        capture,
   output logic [31:0] pc,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4
);

   logic [31:0] pc_r;
   logic [31:0] out_pc_r;
   logic [31:0] out_pc_plus4_r;
   logic [31:0] pc_plus4_s;

   // Next sequential address; wraps naturally modulo 2^32.
   always_comb begin
      pc_plus4_s = pc_r + 32'd4;
   end

   // Redirect load wins over the increment that accompanies a capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r           <= RESET_PC;
         out_pc_r       <= RESET_PC;
         out_pc_plus4_r <= RESET_PC + 32'd4;
      end else begin
         if (load) begin
            pc_r <= align_word(load_pc);
         end else if (capture) begin
            pc_r <= pc_plus4_s;
         end else begin
            pc_r <= pc_r;
         end
         if (capture) begin
            out_pc_r       <= pc_r;
            out_pc_plus4_r <= pc_plus4_s;
         end else begin
            out_pc_r       <= out_pc_r;
            out_pc_plus4_r <= out_pc_plus4_r;
         end
      end
   end

   assign pc           = pc_r;
   assign out_pc       = out_pc_r;
   assign out_pc_plus4 = out_pc_plus4_r;

endmodule

// File: rtl/instr_fetch.sv
// RISC-V fetch stage: one outstanding word read, registered hand-off to
// decode, and redirect handling that discards stale responses.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4
);

   fetch_state_e state_r;
   fetch_state_e state_nxt_s;
   logic         kill_r;
   logic         kill_nxt_s;
   logic         req_valid_r;
   logic         out_valid_r;
   logic         out_valid_nxt_s;
   logic [31:0]  out_instr_r;
   logic         handshake_s;
   logic         capture_s;
   logic         load_s;
   logic [31:0]  pc_s;

   assign handshake_s = req_valid_r & imem_req_ready;

   // Next-state, kill tracking and PC control.
   always_comb begin
      state_nxt_s     = state_r;
      kill_nxt_s      = kill_r;
      out_valid_nxt_s = out_valid_r;
      capture_s       = 1'b0;
      load_s          = 1'b0;
      case (state_r)
         ST_REQ: begin
            // While kill is set no request is driven, so no new acceptance.
            if (kill_r) begin
               kill_nxt_s = ~imem_rsp_valid;
            end else begin
               kill_nxt_s = redirect_valid & handshake_s;
            end
            if (redirect_valid) begin
               load_s = 1'b1;
            end else if (handshake_s) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               kill_nxt_s  = 1'b0;
               state_nxt_s = ST_REQ;
               if (redirect_valid) begin
                  load_s = 1'b1;
               end else if (!kill_r) begin
                  capture_s       = 1'b1;
                  out_valid_nxt_s = 1'b1;
                  state_nxt_s     = ST_HOLD;
               end else begin
                  capture_s = 1'b0;
               end
            end else if (redirect_valid) begin
               load_s     = 1'b1;
               kill_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               load_s          = 1'b1;
               out_valid_nxt_s = 1'b0;
               state_nxt_s     = ST_REQ;
            end else if (out_ready) begin
               out_valid_nxt_s = 1'b0;
               state_nxt_s     = ST_REQ;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s     = ST_REQ;
            kill_nxt_s      = 1'b0;
            out_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State, kill flag and registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_REQ;
         kill_r      <= 1'b0;
         req_valid_r <= 1'b0;
         out_valid_r <= 1'b0;
         out_instr_r <= NOP_INSTR;
      end else begin
         state_r     <= state_nxt_s;
         kill_r      <= kill_nxt_s;
         req_valid_r <= (state_nxt_s == ST_REQ) & ~kill_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         if (capture_s) begin
            out_instr_r <= imem_rsp_data;
         end else begin
            out_instr_r <= out_instr_r;
         end
      end
   end

   fetch_pc_reg #(
      .RESET_PC(RESET_PC)
   ) u_pc_reg (
      .clk          (clk),
      .rst          (rst),
      .load         (load_s),
      .load_pc      (redirect_pc),
      .capture      (capture_s),
      .pc           (pc_s),
      .out_pc       (out_pc),
      .out_pc_plus4 (out_pc_plus4)
   );

   assign imem_req_valid = req_valid_r;
   assign imem_req_addr  = pc_s;
   assign out_valid      = out_valid_r;
   assign out_instr      = out_instr_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable memory responder.
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;

   int checks = 0;
   int errors = 0;
   int mem_k  = 1;
   int pend_cnt = 0;
   logic [31:0] pend_addr = 32'h0;

   instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!out_valid && n < 20);
      check({tag, "_seen"}, {31'd0, out_valid}, 32'd1);
   endtask

   // Memory responder: answers mem_k cycles after acceptance, data = addr ^ A5A5_0000.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         imem_rsp_valid = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = pend_addr ^ 32'hA5A5_0000;
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            pend_cnt  = mem_k;
            pend_addr = imem_req_addr;
         end
      end
   end

   initial begin
      int n;
      rst            = 1'b0;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b1;
      mem_k          = 1;
      step();
      step();
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'h0000_0013);
      check("rst_out_pc", out_pc, 32'h0000_0000);
      check("rst_out_pc_plus4", out_pc_plus4, 32'h0000_0004);
      rst = 1'b1;

      step();
      check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("first_req_addr", imem_req_addr, 32'h0000_0000);
      wait_valid("f0", n);
      check("f0_lat", n, 32'd2);
      check("f0_pc", out_pc, 32'h0000_0000);
      check("f0_instr", out_instr, 32'hA5A5_0000);
      check("f0_pc4", out_pc_plus4, 32'h0000_0004);
      wait_valid("f1", n);
      check("f1_period", n, 32'd3);
      check("f1_pc", out_pc, 32'h0000_0004);
      check("f1_instr", out_instr, 32'hA5A5_0004);
      wait_valid("f2", n);
      check("f2_period", n, 32'd3);
      check("f2_pc", out_pc, 32'h0000_0008);
      check("f2_instr", out_instr, 32'hA5A5_0008);

      // Backpressure in HOLD
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_pc", out_pc, 32'h0000_0008);
         check("bp_instr", out_instr, 32'hA5A5_0008);
         check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      check("bp_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("bp_next_req_addr", imem_req_addr, 32'h0000_000C);
      wait_valid("f3", n);
      check("f3_lat", n, 32'd2);
      check("f3_pc", out_pc, 32'h0000_000C);

      // Redirect one cycle after acceptance, k=3
      mem_k = 3;
      step();
      check("rw_req_addr", imem_req_addr, 32'h0000_0010);
      check("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      step();
      redirect_valid = 1'b0;
      check("rw_kill_blocks_req", {31'd0, imem_req_valid}, 32'd0);
      step();
      step();
      check("rw_new_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("rw_new_req_addr", imem_req_addr, 32'h0000_0100);
      wait_valid("rw", n);
      check("rw_lat", n, 32'd4);
      check("rw_pc", out_pc, 32'h0000_0100);
      check("rw_instr", out_instr, 32'hA5A5_0100);
      mem_k = 1;
      wait_valid("f5", n);
      check("f5_pc", out_pc, 32'h0000_0104);
      check("f5_instr", out_instr, 32'hA5A5_0104);

      // Redirect in HOLD together with out_ready
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      step();
      redirect_valid = 1'b0;
      check("rh_out_valid", {31'd0, out_valid}, 32'd0);
      check("rh_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("rh_req_addr", imem_req_addr, 32'h0000_0040);
      wait_valid("rh", n);
      check("rh_pc", out_pc, 32'h0000_0040);
      check("rh_instr", out_instr, 32'hA5A5_0040);

      // Unaligned redirect and PC wrap
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      step();
      redirect_valid = 1'b0;
      check("wr_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      check("wr_req_valid", {31'd0, imem_req_valid}, 32'd1);
      wait_valid("wr", n);
      check("wr_pc", out_pc, 32'hFFFF_FFFC);
      check("wr_pc4", out_pc_plus4, 32'h0000_0000);
      check("wr_instr", out_instr, 32'h5A5A_FFFC);
      step();
      check("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("wrap_req_addr", imem_req_addr, 32'h0000_0000);
      wait_valid("w0", n);
      check("w0_pc", out_pc, 32'h0000_0000);
      check("w0_instr", out_instr, 32'hA5A5_0000);

      // Reset mid-WAIT with a response arriving during reset
      mem_k = 3;
      step();
      check("rm_req_addr", imem_req_addr, 32'h0000_0004);
      step();
      rst = 1'b0;
      step();
      check("rm_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rm_out_valid", {31'd0, out_valid}, 32'd0);
      check("rm_out_pc", out_pc, 32'h0000_0000);
      step();
      check("rm_rsp_present", {31'd0, imem_rsp_valid}, 32'd1);
      step();
      check("rm_instr_nop", out_instr, 32'h0000_0013);
      check("rm_out_valid2", {31'd0, out_valid}, 32'd0);
      rst   = 1'b1;
      mem_k = 1;
      step();
      check("rm_restart_valid", {31'd0, imem_req_valid}, 32'd1);
      check("rm_restart_addr", imem_req_addr, 32'h0000_0000);
      wait_valid("rm", n);
      check("rm_pc", out_pc, 32'h0000_0000);
      check("rm_instr", out_instr, 32'hA5A5_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the RISC-V core. It owns the program counter and issues one word-aligned read at a time to instruction memory over a valid/ready request channel. It registers the returned word together with its PC and offers it to decode over a valid/ready output channel; decode drives the immediate extender from `out_instr`. Branch and jump redirects from execute flush the in-flight fetch and restart at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: a fetch request is presented.
- `imem_req_ready` in 1: memory accepts the request; the handshake completes when valid and ready are both 1.
- `imem_req_addr` out 32: fetch address, always with [1:0]=2'b00.
- `imem_rsp_valid` in 1: a response word is present, 1-cycle pulse, at least 1 cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: 1-cycle pulse; restart fetch at `redirect_pc`.
- `redirect_pc` in 32: target address; bits [1:0] are ignored and treated as 0.
- `out_valid` out 1: `out_instr`/`out_pc`/`out_pc_plus4` are valid.
- `out_ready` in 1: decode consumes the output.
- `out_instr` out 32: fetched instruction.
- `out_pc` out 32: address of `out_instr`.
- `out_pc_plus4` out 32: `out_pc + 4`, modulo 2^32.

## Operation
- States:
  - REQ: drive the request from `pc`.
  - WAIT: request accepted, awaiting response.
  - HOLD: instruction is held on the output.
- At most one request is outstanding.
- REQ:
  - `imem_req_valid`=1 and `imem_req_addr`=`pc`.
  - On handshake, go to WAIT.
  - If `redirect_valid` occurs in the same cycle, it takes priority: load `pc` from `redirect_pc`, stay in REQ, and ignore any acceptance this cycle. Memory is still allowed to respond to that acceptance; set `kill`=1 so the response is discarded.
- WAIT:
  - On `imem_rsp_valid` with `kill`=0: capture the data into `out_instr` and `pc` into `out_pc`, set `pc`=`pc`+4, set `out_valid`=1, go to HOLD.
  - On `imem_rsp_valid` with `kill`=1: discard the data, clear `kill`, go to REQ.
  - On `redirect_valid` without a response: load `pc`, set `kill`=1, stay in WAIT.
  - On `redirect_valid` and a response in the same cycle: discard the response, load `pc`, go to REQ.
- HOLD:
  - `out_valid`=1 and the outputs are stable.
  - When `out_ready`=1, clear `out_valid` and go to REQ.
  - `redirect_valid` has priority over `out_ready`: clear `out_valid`, load `pc`, go to REQ. The held instruction is not delivered.
- `pc` wraps from 32'hFFFF_FFFC to 0.
- Stray `imem_rsp_valid` in REQ or HOLD is ignored.

## Timing
- Reset (asynchronous, while `rst`=0):
  - state=REQ, `pc`=`RESET_PC`, `kill`=0.
  - `imem_req_valid`=0, `out_valid`=0.
  - `out_instr`=32'h0000_0013 (NOP), `out_pc`=`RESET_PC`, `out_pc_plus4`=`RESET_PC`+4.
- `imem_req_valid` first rises on the first rising edge after `rst` deasserts. It is registered, so it is high from cycle 1.
- Request accepted in cycle N, response in cycle N+k (k≥1): `out_valid` is high from cycle N+k+1.
- With k=1 and `out_ready` tied high, one instruction is delivered every 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A redirect in cycle R puts the new address on `imem_req_addr` in cycle R+1 at the earliest; under `kill` it waits for the stale response first.
- `rst` asserted mid-transaction aborts immediately. A response arriving while in reset is ignored.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (REQ, WAIT, HOLD);
  - `NOP_INSTR`=32'h0000_0013;
  - the default `RESET_PC`.
- `fetch_pc_reg` is the natural sub-module: the PC register with its +4 increment and redirect load mux, also producing `out_pc_plus4`. Everything else stays in `instr_fetch`.

## Test plan
- **Reset and straight-line fetch:** reset, then memory with k=1, data = address ^ 32'hA5A5_0000, `out_ready`=1 → outputs pc 0,4,8 with matching instr, one instruction every 3 cycles; reset values are checked while `rst`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in HOLD → `out_instr`/`out_pc` stable, `imem_req_valid`=0, no new request issued.
- **Redirect during WAIT:** k=3, `redirect_valid` with `redirect_pc`=32'h0000_0100 one cycle after acceptance → stale response discarded, next request address is 0x100, next `out_pc`=0x100.
- **Redirect during HOLD together with `out_ready`=1:** redirect to 0x40 → held instruction not consumed, `out_valid` low for at least one cycle, next `out_pc`=0x40.
- **Unaligned redirect and wrap:** `redirect_pc`=32'hFFFF_FFFE → fetch 0xFFFF_FFFC, `out_pc_plus4`=0, next fetch address 0x0.
- **Reset mid-WAIT, response during reset:** the response arriving during reset is ignored; after release, the fetch restarts at `RESET_PC`.
